// File: rtl/ripple_ctrl_pkg.sv
// Shared definitions for the ripple counter sequencing controller.
// Holds the default parameter values and the controller state encoding.
package ripple_ctrl_pkg;

  localparam int unsigned DEF_WIDTH         = 5;
  localparam int unsigned DEF_PW            = 8;
  localparam int unsigned DEF_SETTLE_CYCLES = 4;

  typedef enum logic [2:0] {
    StIdle,
    StBase,
    StPulseHi,
    StPulseLo,
    StSettle,
    StCheck,
    StDone
  } ripple_ctrl_state_t;

endpackage

// File: rtl/ripple_sync.sv
// Two-flop synchronizer for a multi-bit value that is quasi-static when sampled.
// Ports:
//   clk        - destination clock
//   rst        - synchronous active-high reset, clears both flop stages
//   data_async - input bus from another clock domain
//   data_sync  - bus after two flop stages
module ripple_sync
  import ripple_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_async,
  output logic [WIDTH-1:0] data_sync
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= data_async;
      sync_q <= meta_q;
    end
  end

  assign data_sync = sync_q;

endmodule

// File: rtl/ripple_seq_ctrl.sv
// Sequencer for the ripple counter datapath: issues a programmed number of
// single-cycle pulses into the counter's first stage, lets the ripple settle,
// then samples the synchronized counter and checks it against baseline + pulses.
// Ports:
//   clk       - clock, all state updates on the rising edge
//   rst       - synchronous active-high reset
//   start     - run request, only honoured while idle
//   pulses    - pulse count for the run, latched on the accepted start
//   cnt_in    - counter outputs (asynchronous), bit 0 is the first stage
//   pulse_out - registered clock into the counter's first stage
//   busy      - high from the accepted start until done
//   done      - one-cycle completion strobe
//   sample    - synchronized counter value captured at the end of the run
//   match     - sample equals the expected count; held until the next check
module ripple_seq_ctrl
  import ripple_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH         = DEF_WIDTH,
  parameter int unsigned PW            = DEF_PW,
  parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PW-1:0]    pulses,
  input  logic [WIDTH-1:0] cnt_in,
  output logic             pulse_out,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sample,
  output logic             match
);

  localparam int unsigned WAIT_W = $clog2(SETTLE_CYCLES + 1);
  // BASE spends SETTLE_CYCLES+1 cycles (counter 0..SETTLE_CYCLES) so the first
  // pulse lands SETTLE_CYCLES+1 edges after start; SETTLE spends SETTLE_CYCLES.
  localparam logic [WAIT_W-1:0] BASE_LAST   = WAIT_W'(SETTLE_CYCLES);
  localparam logic [WAIT_W-1:0] SETTLE_LAST = WAIT_W'(SETTLE_CYCLES - 1);

  ripple_ctrl_state_t state_q, state_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [PW-1:0]      remaining_q, remaining_d;
  logic [PW-1:0]      pulses_q, pulses_d;
  logic [WIDTH-1:0]   baseline_q, baseline_d;
  logic [WIDTH-1:0]   sample_q, sample_d;
  logic               match_q, match_d;
  logic               pulse_q, busy_q, done_q;
  logic [WIDTH-1:0]   cnt_sync;
  logic [WIDTH-1:0]   expected;

  ripple_sync #(
    .WIDTH (WIDTH)
  ) u_sync (
    .clk        (clk),
    .rst        (rst),
    .data_async (cnt_in),
    .data_sync  (cnt_sync)
  );

  // Sum in PW+1 bits, then truncate: counter wrap is expected, not an error.
  assign expected = WIDTH'((PW + 1)'(baseline_q) + (PW + 1)'(pulses_q));

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    remaining_d = remaining_q;
    pulses_d    = pulses_q;
    baseline_d  = baseline_q;
    sample_d    = sample_q;
    match_d     = match_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          pulses_d    = pulses;
          remaining_d = pulses;
          wait_d      = '0;
          state_d     = StBase;
        end
      end
      StBase: begin
        if (wait_q == BASE_LAST) begin
          baseline_d = cnt_sync;
          wait_d     = '0;
          state_d    = (remaining_q == '0) ? StSettle : StPulseHi;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      StPulseHi: begin
        state_d = StPulseLo;
      end
      StPulseLo: begin
        remaining_d = remaining_q - PW'(1);
        wait_d      = '0;
        state_d     = (remaining_q == PW'(1)) ? StSettle : StPulseHi;
      end
      StSettle: begin
        if (wait_q == SETTLE_LAST) begin
          wait_d  = '0;
          state_d = StCheck;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      StCheck: begin
        sample_d = cnt_sync;
        match_d  = (cnt_sync == expected);
        state_d  = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      wait_q      <= '0;
      remaining_q <= '0;
      pulses_q    <= '0;
      baseline_q  <= '0;
      sample_q    <= '0;
      match_q     <= 1'b0;
      pulse_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      remaining_q <= remaining_d;
      pulses_q    <= pulses_d;
      baseline_q  <= baseline_d;
      sample_q    <= sample_d;
      match_q     <= match_d;
      // Outputs are decoded from the next state so they are glitch-free flops
      // that line up with the state they describe.
      pulse_q     <= (state_d == StPulseHi);
      busy_q      <= (state_d != StIdle) && (state_d != StDone);
      done_q      <= (state_d == StDone);
    end
  end

  assign pulse_out = pulse_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign sample    = sample_q;
  assign match     = match_q;

endmodule

// File: doc/ripple_seq_ctrl.md
# ripple_seq_ctrl

Synchronous controller for the five-stage ripple counter datapath. It issues a programmed number of clock pulses into the counter's first stage and waits for the asynchronous ripple to settle. It then samples the counter outputs through a synchronizer and checks the result against the expected count. It sits between the test/host logic, which drives `start`/`pulses`, and the ripple counter, which receives `pulse_out` and returns its outputs on `cnt_in`.

## Interface
- `WIDTH`, 5: number of ripple stages / bits on `cnt_in`.
- `PW`, 8: width of the `pulses` request.
- `SETTLE_CYCLES`, 4: cycles waited before each sample. Legal range is ≥3.
- `clk` input 1: single clock. All state is updated on its rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `start` input 1: request a run. Sampled only in IDLE.
- `pulses` input PW: number of counter pulses for the run. Latched when `start` is accepted.
- `cnt_in` input WIDTH: counter outputs, bit0 = first stage. Asynchronous to `clk`.
- `pulse_out` output 1: drives the counter's first-stage clock. Registered.
- `busy` output 1: high from the accepted start until `done`.
- `done` output 1: one-cycle completion pulse.
- `sample` output WIDTH: synchronized counter value captured in CHECK.
- `match` output 1: `sample == expected`. Valid while `done` is high and held afterwards.

## Operation
- `cnt_in` passes through a two-flop synchronizer before any use.
- FSM states: IDLE, BASE, PULSE_HI, PULSE_LO, SETTLE, CHECK, DONE.
- IDLE: when `start`=1, latch `pulses` into `remaining`, clear the wait counter, set `busy`=1, and go to BASE. While busy, further `start` inputs are ignored.
- BASE: wait SETTLE_CYCLES cycles, then capture `baseline` from the synchronized counter.
  - If `remaining`=0, go to SETTLE.
  - Otherwise go to PULSE_HI.
- PULSE_HI: `pulse_out`=1 for exactly one cycle, then go to PULSE_LO.
- PULSE_LO: `pulse_out`=0 for exactly one cycle and decrement `remaining`.
  - If `remaining` becomes 0, go to SETTLE.
  - Otherwise go to PULSE_HI.
- SETTLE: wait SETTLE_CYCLES cycles, then go to CHECK.
- CHECK (1 cycle):
  - `sample` ← synchronized counter value.
  - `match` ← (`sample` == `expected`), where `expected` = (`baseline` + `pulses`) mod 2^WIDTH.
  - The sum is computed in PW+1 bits and truncated to WIDTH bits, so counter wrap-around is expected behaviour, not an error.
  - Go to DONE.
- DONE (1 cycle): `done`=1, `busy`=0 in that same cycle, then go to IDLE.
- `sample` and `match` hold until the next CHECK.
- `pulse_out` is 0 in every state except PULSE_HI.
- Reset values: state=IDLE; `pulse_out`, `busy`, `done`, `match` = 0; `sample`, `baseline`, `remaining`, and the synchronizer flops = 0.
- Reset mid-run: on the next edge all outputs take their reset values. Any in-flight pulse is truncated and no `done` is produced. The counter itself is not reset by this block.
- If `start` and `rst` are high on the same edge, `rst` wins.

## Timing
- Accepted `start` at edge t0: `busy` is visible after t0.
- `pulse_out` rises after edge t0+SETTLE_CYCLES+1.
- Pulse k (k=0..P-1) is high during cycle t0+SETTLE_CYCLES+1+2k.
- `done` is high for exactly one cycle, following edge t0 + 2·SETTLE_CYCLES + 2·P + 2.
  - Defaults, P=3: done after t0+16.
  - P=0: done after t0+10.
- A new `start` is accepted at earliest on the edge after `done` is high.
- Maximum run length is P = 2^PW − 1. No overflow is possible because `remaining` is PW bits wide and only counts down.

## Structure
- Package `ripple_ctrl_pkg` holds:
  - the state enum `ripple_ctrl_state_t`;
  - default localparams for WIDTH, PW and SETTLE_CYCLES.
- Sub-module `ripple_sync`: a parameterized WIDTH-bit two-flop synchronizer with synchronous active-high reset. It is instantiated once on `cnt_in`.
- The FSM, the wait counter, `remaining`, and the expected-value arithmetic stay in `ripple_seq_ctrl`.

## Test plan
- Reset held for 3 cycles, then released with `start`=0 → all outputs 0, state IDLE; `pulse_out` never toggles.
- Counter at 0, `start` with `pulses`=3 → exactly 3 one-cycle `pulse_out` highs; `done` after t0+16; `sample`=3, `match`=1.
- Counter at 5, `pulses`=33 with WIDTH=5 → `expected`=6 (wrap); `sample`=6, `match`=1.
- `pulses`=0 → no `pulse_out` activity; `done` after t0+10; `sample`=`baseline`, `match`=1.
- `start` pulsed again during the pulse phase → ignored: total pulse count unchanged and one `done` only.
- `rst` asserted during PULSE_HI → `pulse_out`=0, `busy`=0 after the next edge, and no `done`. Separately, a counter model with stage 0 stuck at 0 and `pulses`=1 → `match`=0.
